ofm_writer: RTL and testbench

Downstream stage of the MITO accelerator output path. Accepts the 8-bit OFM stream leaving the OFM buffer through a valid/ready handshake. Packs four consecutive values into one 32-bit word, queues words in a small FIFO and writes them to on-chip memory at consecutive word addresses. Signals `done` once the programmed number of OFM values has been written, flushing a final partial word with byte strobes.

---
 rtl/ofm_writer.sv | 168 ++++++++++++++++
 tb/tb_ofm_writer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writer.sv
// ofm_writer: packs the 8-bit OFM stream into 32-bit words, queues them in a
// small FIFO and writes them to consecutive word addresses. The final partial
// word carries byte strobes, and done pulses once the job has fully drained.
module ofm_writer #(
    parameter int OFM_WIDTH  = 8,
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 16,
    localparam int LANES     = WORD_WIDTH / OFM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_pixels,
    input  logic                  ofm_valid,
    input  logic [OFM_WIDTH-1:0]  ofm_data,
    output logic                  ofm_ready,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic [LANES-1:0]      mem_strb,
    output logic                  busy,
    output logic                  done
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LANE_W-1:0]     lane;
    logic [WORD_WIDTH-1:0] pack_data;
    logic [LANES-1:0]      pack_strb;
    logic [WORD_WIDTH-1:0] next_data;
    logic [LANES-1:0]      next_strb;

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [LANES-1:0]      fifo_strb [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic last_value;
    logic push;
    logic pop;

    assign fifo_full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign ofm_ready  = (state == S_PACK) && !fifo_full;
    assign accept     = ofm_valid && ofm_ready;
    assign last_value = (remaining == ADDR_WIDTH'(1));
    assign push       = accept && ((lane == LANE_W'(LANES - 1)) || last_value);
    assign pop        = mem_valid && mem_ready;

    assign mem_valid = !fifo_empty;
    assign mem_addr  = mem_valid ? fifo_addr[rd_ptr] : '0;
    assign mem_data  = mem_valid ? fifo_data[rd_ptr] : '0;
    assign mem_strb  = mem_valid ? fifo_strb[rd_ptr] : '0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // Merge the incoming value into the current lane of the pack register.
    always_comb begin
        next_data = pack_data;
        next_strb = pack_strb;
        next_data[lane * OFM_WIDTH +: OFM_WIDTH] = ofm_data;
        next_strb[lane] = 1'b1;
    end

    // Job sequencing, lane packing and address generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            wr_addr   <= '0;
            lane      <= '0;
            pack_data <= '0;
            pack_strb <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= num_pixels;
                        wr_addr   <= base_addr;
                        lane      <= '0;
                        pack_data <= '0;
                        pack_strb <= '0;
                        state     <= (num_pixels != '0) ? S_PACK : S_DONE;
                    end
                end
                S_PACK: begin
                    if (accept) begin
                        remaining <= remaining - ADDR_WIDTH'(1);
                        if (push) begin
                            pack_data <= '0;
                            pack_strb <= '0;
                            lane      <= '0;
                            wr_addr   <= wr_addr + ADDR_WIDTH'(1);
                        end else begin
                            pack_data <= next_data;
                            pack_strb <= next_strb;
                            lane      <= lane + LANE_W'(1);
                        end
                        if (last_value) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty || (count == (PTR_W + 1)'(1) && pop)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; reset discards any queued words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    // FIFO storage; the word written is the pack register with the new value merged in.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= next_data;
            fifo_strb[wr_ptr] <= next_strb;
        end
    end

endmodule

// File: tb/tb_ofm_writer.sv
// tb_ofm_writer: table-driven jobs plus hand-written backpressure, zero-job,
// reset-abort sequences for ofm_writer.
module tb_ofm_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_pixels;
    logic        ofm_valid;
    logic [7:0]  ofm_data;
    logic        ofm_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_strb;
    logic        busy;
    logic        done;

    ofm_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_pixels (num_pixels),
        .ofm_valid  (ofm_valid),
        .ofm_data   (ofm_data),
        .ofm_ready  (ofm_ready),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_strb   (mem_strb),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [15:0] base;
        logic [15:0] num;
        logic [63:0] vals;
        int          nwords;
        logic [15:0] addr0;
        logic [31:0] data0;
        logic [3:0]  strb0;
        logic [15:0] addr1;
        logic [31:0] data1;
        logic [3:0]  strb1;
    } job_t;

    job_t        jobs [5];
    logic [7:0]  stim [64];
    logic [15:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    int          wq_cyc [$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;
    logic [3:0]  prev_strb;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time writes against done.
    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Memory-side monitor: idle outputs zero, stalled requests hold, writes are logged.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (!mem_valid) begin
                check_output("idle mem_addr", {16'b0, mem_addr}, 32'h0);
                check_output("idle mem_data", mem_data, 32'h0);
                check_output("idle mem_strb", {28'b0, mem_strb}, 32'h0);
            end
            if (prev_stall) begin
                check_output("stall mem_valid", {31'b0, mem_valid}, 32'h1);
                check_output("stall mem_addr", {16'b0, mem_addr}, {16'b0, prev_addr});
                check_output("stall mem_data", mem_data, prev_data);
                check_output("stall mem_strb", {28'b0, mem_strb}, {28'b0, prev_strb});
            end
            if (mem_valid && mem_ready) begin
                wq_addr.push_back(mem_addr);
                wq_data.push_back(mem_data);
                wq_strb.push_back(mem_strb);
                wq_cyc.push_back(cycle);
            end
            prev_stall = mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
            prev_strb  = mem_strb;
        end
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_strb.delete();
        wq_cyc.delete();
    endtask

    task automatic apply_stimulus(input logic [15:0] base, input logic [15:0] num);
        start      = 1'b1;
        base_addr  = base;
        num_pixels = num;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic stream(input int from, input int n, input int max_cycles,
                          output int accepted, output int used);
        logic rdy;
        accepted = 0;
        used = 0;
        while (accepted < n && used < max_cycles) begin
            ofm_valid = 1'b1;
            ofm_data  = stim[from + accepted];
            @(negedge clk);
            rdy = ofm_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted++;
            used++;
        end
        ofm_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output logic seen);
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dcyc = cycle;
                break;
            end
        end
        check_output("done seen", {31'b0, seen}, 32'h1);
        @(posedge clk);
        #1;
        check_output("busy after done", {31'b0, busy}, 32'h0);
        check_output("done one cycle", {31'b0, done}, 32'h0);
    endtask

    task automatic run_table_job(input int j);
        int   acc;
        int   used;
        int   dcyc;
        logic seen;
        clear_log();
        for (int i = 0; i < 8; i++) stim[i] = jobs[j].vals[8*i +: 8];
        mem_ready = 1'b1;
        apply_stimulus(jobs[j].base, jobs[j].num);
        check_output("busy after start", {31'b0, busy}, 32'h1);
        check_output("ready after start", {31'b0, ofm_ready}, 32'h1);
        stream(0, int'(jobs[j].num), int'(jobs[j].num) + 20, acc, used);
        check_output("accepted", acc, jobs[j].num);
        check_output("stream cycles", used, jobs[j].num);
        wait_done(50, dcyc, seen);
        check_output("write count", wq_addr.size(), jobs[j].nwords);
        for (int k = 0; k < jobs[j].nwords; k++) begin
            if (wq_addr.size() > k) begin
                check_output("word addr", {16'b0, wq_addr[k]}, {16'b0, (k == 0) ? jobs[j].addr0 : jobs[j].addr1});
                check_output("word data", wq_data[k], (k == 0) ? jobs[j].data0 : jobs[j].data1);
                check_output("word strb", {28'b0, wq_strb[k]}, {28'b0, (k == 0) ? jobs[j].strb0 : jobs[j].strb1});
            end
        end
        if (seen && wq_cyc.size() > 0) begin
            check_output("done after last write", dcyc, wq_cyc[wq_cyc.size() - 1] + 1);
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got running, expected finished");
        $fatal(1, "[TB] global timeout");
    end

    // Main test sequence.
    initial begin
        int   acc;
        int   used;
        int   dcyc;
        logic seen;

        jobs[0] = '{16'h0010, 16'd8, 64'h0807060504030201, 2,
                    16'h0010, 32'h04030201, 4'hF, 16'h0011, 32'h08070605, 4'hF};
        jobs[1] = '{16'h0040, 16'd6, 64'h00002211007F80FF, 2,
                    16'h0040, 32'h007F80FF, 4'hF, 16'h0041, 32'h00002211, 4'h3};
        jobs[2] = '{16'hFFFF, 16'd8, 64'hA7A6A5A4A3A2A1A0, 2,
                    16'hFFFF, 32'hA3A2A1A0, 4'hF, 16'h0000, 32'hA7A6A5A4, 4'hF};
        jobs[3] = '{16'h1234, 16'd3, 64'h000000000001C35A, 1,
                    16'h1234, 32'h0001C35A, 4'h7, 16'h0000, 32'h00000000, 4'h0};
        jobs[4] = '{16'h0300, 16'd5, 64'h0000005040302010, 2,
                    16'h0300, 32'h40302010, 4'hF, 16'h0301, 32'h00000050, 4'h1};

        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_pixels = '0;
        ofm_valid  = 1'b0;
        ofm_data   = '0;
        mem_ready  = 1'b0;

        @(negedge clk);
        check_output("reset ofm_ready", {31'b0, ofm_ready}, 32'h0);
        check_output("reset mem_valid", {31'b0, mem_valid}, 32'h0);
        check_output("reset busy", {31'b0, busy}, 32'h0);
        check_output("reset done", {31'b0, done}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table-driven jobs");
        for (int j = 0; j < 5; j++) begin
            run_table_job(j);
        end

        $display("[TB] backpressure job");
        clear_log();
        for (int i = 0; i < 32; i++) stim[i] = 8'(i);
        mem_ready = 1'b0;
        apply_stimulus(16'h0500, 16'd32);
        stream(0, 32, 30, acc, used);
        check_output("bp accepted", acc, 16);
        check_output("bp ofm_ready", {31'b0, ofm_ready}, 32'h0);
        check_output("bp mem_valid", {31'b0, mem_valid}, 32'h1);
        check_output("bp head addr", {16'b0, mem_addr}, 32'h0500);
        check_output("bp head data", mem_data, 32'h03020100);
        mem_ready = 1'b1;
        stream(16, 16, 60, acc, used);
        check_output("bp accepted after release", acc, 16);
        wait_done(50, dcyc, seen);
        check_output("bp write count", wq_addr.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (wq_addr.size() > k) begin
                check_output("bp addr", {16'b0, wq_addr[k]}, 32'h0500 + k);
                check_output("bp data", wq_data[k],
                             {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)});
                check_output("bp strb", {28'b0, wq_strb[k]}, 32'hF);
            end
        end

        $display("[TB] zero-length job");
        clear_log();
        apply_stimulus(16'h0600, 16'd0);
        check_output("zero done", {31'b0, done}, 32'h1);
        check_output("zero busy", {31'b0, busy}, 32'h1);
        apply_stimulus(16'h0700, 16'd4);
        check_output("ignored start busy", {31'b0, busy}, 32'h0);
        check_output("ignored start done", {31'b0, done}, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        check_output("zero no writes", wq_addr.size(), 0);
        check_output("zero stays idle", {31'b0, busy}, 32'h0);

        $display("[TB] reset mid-job");
        clear_log();
        for (int i = 0; i < 8; i++) stim[i] = 8'h31 + 8'(i);
        mem_ready = 1'b1;
        apply_stimulus(16'h0100, 16'd8);
        stream(0, 5, 30, acc, used);
        check_output("pre-reset accepted", acc, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("abort ofm_ready", {31'b0, ofm_ready}, 32'h0);
        check_output("abort mem_valid", {31'b0, mem_valid}, 32'h0);
        check_output("abort mem_addr", {16'b0, mem_addr}, 32'h0);
        check_output("abort mem_data", mem_data, 32'h0);
        check_output("abort mem_strb", {28'b0, mem_strb}, 32'h0);
        check_output("abort busy", {31'b0, busy}, 32'h0);
        check_output("abort done", {31'b0, done}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        for (int i = 0; i < 4; i++) stim[i] = 8'h41 + 8'(i);
        apply_stimulus(16'h0200, 16'd4);
        stream(0, 4, 20, acc, used);
        wait_done(50, dcyc, seen);
        check_output("post-reset write count", wq_addr.size(), 1);
        if (wq_addr.size() > 0) begin
            check_output("post-reset addr", {16'b0, wq_addr[0]}, 32'h0200);
            check_output("post-reset data", wq_data[0], 32'h44434241);
            check_output("post-reset strb", {28'b0, wq_strb[0]}, 32'hF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
